// File: rtl/sync_pkg.sv
// Shared constants and helpers for the synchronizer bank.
package sync_pkg;

    localparam int SYNC_MIN_STAGES = 2;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/sync_chan.sv
// One channel: STAGES-deep synchronizer, optional stability filter, registered rise/fall pulses.
// Latency STAGES+1 edges unfiltered, STAGES+FILTER edges filtered; no backpressure.
module sync_chan
    import sync_pkg::*;
#(
    parameter int   STAGES  = 2,
    parameter int   FILTER  = 0,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic d_out,
    output logic rise,
    output logic fall
);

    if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
        $error("sync_chan: STAGES must be at least %0d", SYNC_MIN_STAGES);
    end

    // First stage samples an asynchronous input; keep the chain packed together.
    (* async_reg = "true" *) logic [STAGES-1:0] chain_q;
    logic sync_end;
    logic d_out_q, d_out_d;
    logic rise_q, fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= {STAGES{RST_VAL}};
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_in};
        end
    end

    assign sync_end = chain_q[STAGES-1];

    if (FILTER == 0) begin : g_nofilt
        assign d_out_d = sync_end;
    end else begin : g_filt
        localparam int CW = clog2(FILTER + 1);
        logic [CW-1:0] cnt_q, cnt_d;

        // Count consecutive mismatch cycles; the FILTER-th one commits the new level.
        always_comb begin
            cnt_d   = '0;
            d_out_d = d_out_q;
            if (sync_end != d_out_q) begin
                if (cnt_q == CW'(FILTER - 1)) begin
                    d_out_d = sync_end;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    // Pulses derive from the next level so they line up with the d_out change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_out_q <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            d_out_q <= d_out_d;
            rise_q  <= d_out_d & ~d_out_q;
            fall_q  <= ~d_out_d & d_out_q;
        end
    end

    assign d_out = d_out_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/sync_bank.sv
// Bank of CHANNELS independent single-bit synchronizers with optional glitch filter and edge pulses.
// Latency STAGES+1 edges (FILTER=0) or STAGES+FILTER edges; no backpressure, inputs sampled every cycle.
module sync_bank
    import sync_pkg::*;
#(
    parameter int                  CHANNELS = 4,
    parameter int                  STAGES   = 2,
    parameter int                  FILTER   = 0,
    parameter logic [CHANNELS-1:0] RST_VAL  = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] d_in,
    output logic [CHANNELS-1:0] d_out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        sync_chan #(
            .STAGES  (STAGES),
            .FILTER  (FILTER),
            .RST_VAL (RST_VAL[i])
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .d_in  (d_in[i]),
            .d_out (d_out[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

endmodule

// File: tb/tb_sync_bank.sv
// Four bank configurations run in lockstep; expectations are queued at drive time and checked at negedge.
module tb_sync_bank;

    typedef struct {
        int         inst;
        int         cyc;
        logic [3:0] d;
        logic [3:0] r;
        logic [3:0] f;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] din  [4];
    logic [3:0] dout [4];
    logic [3:0] rise [4];
    logic [3:0] fall [4];
    logic [3:0] last [4];
    logic [3:0] rstv [4];
    int         lat  [4];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    exp_t       sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // inst0: defaults; inst1: FILTER=3; inst2: STAGES=3; inst3: RST_VAL=1010
    sync_bank #(.CHANNELS(4), .STAGES(2), .FILTER(0), .RST_VAL(4'b0000)) u0 (
        .clk(clk), .rst_n(rst_n), .d_in(din[0]), .d_out(dout[0]), .rise(rise[0]), .fall(fall[0]));
    sync_bank #(.CHANNELS(4), .STAGES(2), .FILTER(3), .RST_VAL(4'b0000)) u1 (
        .clk(clk), .rst_n(rst_n), .d_in(din[1]), .d_out(dout[1]), .rise(rise[1]), .fall(fall[1]));
    sync_bank #(.CHANNELS(4), .STAGES(3), .FILTER(0), .RST_VAL(4'b0000)) u2 (
        .clk(clk), .rst_n(rst_n), .d_in(din[2]), .d_out(dout[2]), .rise(rise[2]), .fall(fall[2]));
    sync_bank #(.CHANNELS(4), .STAGES(2), .FILTER(0), .RST_VAL(4'b1010)) u3 (
        .clk(clk), .rst_n(rst_n), .d_in(din[3]), .d_out(dout[3]), .rise(rise[3]), .fall(fall[3]));

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic push(input int inst, input int at, input logic [3:0] d,
                        input logic [3:0] r, input logic [3:0] f);
        exp_t e;
        e.inst = inst; e.cyc = at; e.d = d; e.r = r; e.f = f;
        sb.push_back(e);
    endtask

    task automatic check_now();
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].cyc == cyc) begin
                exp_t e;
                e = sb[k];
                sb.delete(k);
                chk($sformatf("i%0d_c%0d_dout", e.inst, e.cyc), dout[e.inst], e.d);
                chk($sformatf("i%0d_c%0d_rise", e.inst, e.cyc), rise[e.inst], e.r);
                chk($sformatf("i%0d_c%0d_fall", e.inst, e.cyc), fall[e.inst], e.f);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_now();
    endtask

    // One clock of stimulus; unfiltered instances get their expected level/pulse queued.
    task automatic cycle(input logic [3:0] v0, input logic [3:0] v1,
                         input logic [3:0] v2, input logic [3:0] v3);
        logic [3:0] v [4];
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
        for (int i = 0; i < 4; i++) begin
            din[i] = v[i];
            if (i != 1) begin
                push(i, cyc + lat[i], v[i], v[i] & ~last[i], ~v[i] & last[i]);
                last[i] = v[i];
            end
        end
        step();
    endtask

    initial begin
        int c;
        lat[0] = 3; lat[1] = 5; lat[2] = 4; lat[3] = 3;
        rstv[0] = 4'b0000; rstv[1] = 4'b0000; rstv[2] = 4'b0000; rstv[3] = 4'b1010;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) din[i] = 4'b0000;
        step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_dout_i%0d", i), dout[i], rstv[i]);
            chk($sformatf("rst_rise_i%0d", i), rise[i], 4'b0000);
            chk($sformatf("rst_fall_i%0d", i), fall[i], 4'b0000);
        end
        step();

        // Release: reset levels hold until the pipeline refills.
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            last[i] = rstv[i];
            if (i != 1)
                for (int k = 1; k < lat[i]; k++) push(i, cyc + k, rstv[i], 4'b0000, 4'b0000);
        end
        cycle(4'b0001, 4'b0000, 4'b1111, 4'b0000);
        repeat (4) cycle(4'b0001, 4'b0000, 4'b1111, 4'b0000);

        // Two-cycle pulse on the filtered instance must be rejected.
        c = cyc;
        for (int k = 1; k <= 8; k++) push(1, c + k, 4'b0000, 4'b0000, 4'b0000);
        repeat (2) cycle(4'b0000, 4'b0010, 4'b1111, 4'b0000);
        repeat (6) cycle(4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Held input passes the filter after STAGES+FILTER edges; all-rise, then fall[3],fall[1], then alternation.
        c = cyc;
        push(1, c + 4, 4'b0000, 4'b0000, 4'b0000);
        push(1, c + 5, 4'b0010, 4'b0010, 4'b0000);
        push(1, c + 6, 4'b0010, 4'b0000, 4'b0000);
        cycle(4'b1111, 4'b0010, 4'b0101, 4'b0000);
        cycle(4'b0101, 4'b0010, 4'b0101, 4'b0000);
        cycle(4'b0111, 4'b0010, 4'b0101, 4'b0000);
        cycle(4'b0101, 4'b0010, 4'b0101, 4'b0000);
        cycle(4'b0111, 4'b0010, 4'b0000, 4'b0000);
        cycle(4'b0101, 4'b0010, 4'b0000, 4'b0000);
        repeat (4) cycle(4'b0101, 4'b0010, 4'b0000, 4'b0000);

        c = cyc;
        push(1, c + 4, 4'b0010, 4'b0000, 4'b0000);
        push(1, c + 5, 4'b0000, 4'b0000, 4'b0010);
        push(1, c + 6, 4'b0000, 4'b0000, 4'b0000);
        repeat (7) cycle(4'b0101, 4'b0000, 4'b0000, 4'b0000);

        // Park the other instances at their reset levels so reset does not disturb them.
        repeat (5) cycle(4'b0000, 4'b0000, 4'b0000, 4'b1010);

        // Reset after two mismatch cycles discards the partial count.
        c = cyc;
        for (int k = 1; k <= 4; k++) push(1, c + k, 4'b0000, 4'b0000, 4'b0000);
        repeat (4) cycle(4'b0000, 4'b0001, 4'b0000, 4'b1010);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_dout", dout[1], 4'b0000);
        chk("rst_mid_rise", rise[1], 4'b0000);
        chk("rst_mid_fall", fall[1], 4'b0000);
        repeat (2) cycle(4'b0000, 4'b0001, 4'b0000, 4'b1010);
        rst_n = 1'b1;
        c = cyc;
        for (int k = 1; k <= 4; k++) push(1, c + k, 4'b0000, 4'b0000, 4'b0000);
        push(1, c + 5, 4'b0001, 4'b0001, 4'b0000);
        push(1, c + 6, 4'b0001, 4'b0000, 4'b0000);
        repeat (8) cycle(4'b0000, 4'b0001, 4'b0000, 4'b1010);

        for (int k = 0; k < 20 && sb.size() != 0; k++) step();
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL drain observed=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
